// File: rtl/mix_optim.sv
// mix_optim: momentum-SGD optimiser sweep over weight/velocity/gradient RAMs.
//
// A pass is started from IDLE by `update` (priority) or `zero_grad`.
//   update    : reads w, v, g at every address 0..DEPTH-1 and writes back
//               v' = sat(v - (v>>>MOM_SHIFT) + g), w' = sat(w - (v'>>>LR_SHIFT))
//               for each of the LANES signed WIDTH-bit lanes of a RAM word.
//   zero_grad : writes 0 to every gradient RAM word.
// Each pass ends with a one-cycle valid_* pulse in the same cycle that busy
// falls, and a new request is accepted in that same cycle.
//
// Ports
//   clk, rst                       clock, synchronous active-high reset
//   update, zero_grad              start requests (sampled only in IDLE)
//   valid_update, valid_zero_grad  one-cycle completion pulses
//   busy                           high whenever not IDLE
//   raddr                          shared read address (data one cycle later)
//   rdata_w/_v/_grad               read data
//   waddr, wdata_w/_v/_grad        shared write address, write data
//   we_w, we_v, we_grad            write enables
module mix_optim #(
  parameter int ADDR_WIDTH = 9,
  parameter int DEPTH      = 384,
  parameter int LANES      = 16,
  parameter int WIDTH      = 16,
  parameter int MOM_SHIFT  = 3,
  parameter int LR_SHIFT   = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     update,
  input  logic                     zero_grad,
  output logic                     valid_update,
  output logic                     valid_zero_grad,
  output logic                     busy,
  output logic [ADDR_WIDTH-1:0]    raddr,
  input  logic [LANES*WIDTH-1:0]   rdata_w,
  input  logic [LANES*WIDTH-1:0]   rdata_v,
  input  logic [LANES*WIDTH-1:0]   rdata_grad,
  output logic [ADDR_WIDTH-1:0]    waddr,
  output logic [LANES*WIDTH-1:0]   wdata_w,
  output logic [LANES*WIDTH-1:0]   wdata_v,
  output logic [LANES*WIDTH-1:0]   wdata_grad,
  output logic                     we_w,
  output logic                     we_v,
  output logic                     we_grad
);

  localparam int EW = WIDTH + 2;
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DEPTH - 1);
  localparam logic signed [EW-1:0] SAT_MAX = {3'b000, {(WIDTH-1){1'b1}}};
  localparam logic signed [EW-1:0] SAT_MIN = {3'b111, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, UPD, UPD_DRAIN, ZERO} state_t;

  state_t                  state_q;
  logic                    drain_q;
  logic                    vld_p0;      // raddr currently carries a live read
  logic                    vld_p1;      // rdata_* currently carries live data
  logic [ADDR_WIDTH-1:0]   addr_p1;
  logic [LANES*WIDTH-1:0]  w_new_p1;
  logic [LANES*WIDTH-1:0]  v_new_p1;

  function automatic logic signed [WIDTH-1:0] sat(input logic signed [EW-1:0] x);
    if (x > SAT_MAX)      return SAT_MAX[WIDTH-1:0];
    else if (x < SAT_MIN) return SAT_MIN[WIDTH-1:0];
    else                  return x[WIDTH-1:0];
  endfunction

  function automatic logic signed [WIDTH-1:0] next_v(input logic signed [WIDTH-1:0] v,
                                                    input logic signed [WIDTH-1:0] g);
    logic signed [EW-1:0] vx;
    logic signed [EW-1:0] gx;
    vx = EW'(v);
    gx = EW'(g);
    return sat(vx - (vx >>> MOM_SHIFT) + gx);
  endfunction

  // Takes the already-saturated v' so a clamped velocity drives the step.
  function automatic logic signed [WIDTH-1:0] next_w(input logic signed [WIDTH-1:0] w,
                                                    input logic signed [WIDTH-1:0] vn);
    logic signed [EW-1:0] wx;
    logic signed [EW-1:0] vx;
    wx = EW'(w);
    vx = EW'(vn);
    return sat(wx - (vx >>> LR_SHIFT));
  endfunction

  // ---- stage p1: read data arrives, lane arithmetic ----
  always_comb begin
    w_new_p1 = '0;
    v_new_p1 = '0;
    for (int l = 0; l < LANES; l++) begin
      logic signed [WIDTH-1:0] vn;
      vn = next_v(signed'(rdata_v[l*WIDTH +: WIDTH]), signed'(rdata_grad[l*WIDTH +: WIDTH]));
      v_new_p1[l*WIDTH +: WIDTH] = vn;
      w_new_p1[l*WIDTH +: WIDTH] = next_w(signed'(rdata_w[l*WIDTH +: WIDTH]), vn);
    end
  end

  // ---- stage p2: registered write-back plus FSM ----
  always_ff @(posedge clk) begin
    addr_p1 <= raddr;
    if (rst) begin
      state_q         <= IDLE;
      drain_q         <= 1'b0;
      vld_p0          <= 1'b0;
      vld_p1          <= 1'b0;
      busy            <= 1'b0;
      valid_update    <= 1'b0;
      valid_zero_grad <= 1'b0;
      raddr           <= '0;
      waddr           <= '0;
      we_w            <= 1'b0;
      we_v            <= 1'b0;
      we_grad         <= 1'b0;
      wdata_w         <= '0;
      wdata_v         <= '0;
      wdata_grad      <= '0;
    end else begin
      valid_update    <= 1'b0;
      valid_zero_grad <= 1'b0;
      vld_p0          <= 1'b0;
      we_grad         <= 1'b0;
      vld_p1          <= vld_p0;
      we_w            <= vld_p1;
      we_v            <= vld_p1;
      if (vld_p1) begin
        waddr   <= addr_p1;
        wdata_w <= w_new_p1;
        wdata_v <= v_new_p1;
      end

      // Update and zero passes never overlap, so the shared waddr has one
      // owner at a time.
      case (state_q)
        IDLE: begin
          if (update) begin
            state_q <= UPD;
            busy    <= 1'b1;
            raddr   <= '0;
            vld_p0  <= 1'b1;
          end else if (zero_grad) begin
            state_q    <= ZERO;
            busy       <= 1'b1;
            waddr      <= '0;
            we_grad    <= 1'b1;
            wdata_grad <= '0;
          end
        end
        UPD: begin
          if (raddr == LAST) begin
            state_q <= UPD_DRAIN;
            drain_q <= 1'b0;
          end else begin
            raddr  <= raddr + ADDR_WIDTH'(1);
            vld_p0 <= 1'b1;
          end
        end
        // Two cycles for the last read to reach the write port.
        UPD_DRAIN: begin
          if (drain_q) begin
            state_q      <= IDLE;
            busy         <= 1'b0;
            valid_update <= 1'b1;
          end else begin
            drain_q <= 1'b1;
          end
        end
        ZERO: begin
          if (waddr == LAST) begin
            state_q         <= IDLE;
            busy            <= 1'b0;
            valid_zero_grad <= 1'b1;
          end else begin
            waddr   <= waddr + ADDR_WIDTH'(1);
            we_grad <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mix_optim.sv
module tb_mix_optim;
  localparam int AW    = 9;
  localparam int DEPTH = 4;
  localparam int LANES = 2;
  localparam int WIDTH = 16;
  localparam int DW    = LANES * WIDTH;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, update, zero_grad;
  logic          valid_update, valid_zero_grad, busy;
  logic [AW-1:0] raddr, waddr;
  logic [DW-1:0] rdata_w, rdata_v, rdata_grad;
  logic [DW-1:0] wdata_w, wdata_v, wdata_grad;
  logic          we_w, we_v, we_grad;

  mix_optim #(.ADDR_WIDTH(AW), .DEPTH(DEPTH), .LANES(LANES), .WIDTH(WIDTH),
              .MOM_SHIFT(3), .LR_SHIFT(4)) dut (
    .clk(clk), .rst(rst), .update(update), .zero_grad(zero_grad),
    .valid_update(valid_update), .valid_zero_grad(valid_zero_grad), .busy(busy),
    .raddr(raddr), .rdata_w(rdata_w), .rdata_v(rdata_v), .rdata_grad(rdata_grad),
    .waddr(waddr), .wdata_w(wdata_w), .wdata_v(wdata_v), .wdata_grad(wdata_grad),
    .we_w(we_w), .we_v(we_v), .we_grad(we_grad));

  // RAMs with one-cycle registered read and a backdoor load port
  logic [DW-1:0] mem_w [512];
  logic [DW-1:0] mem_v [512];
  logic [DW-1:0] mem_g [512];
  logic          ld_en;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] ld_w, ld_v, ld_g;

  always @(posedge clk) begin
    rdata_w    <= mem_w[raddr];
    rdata_v    <= mem_v[raddr];
    rdata_grad <= mem_g[raddr];
    if (ld_en) begin
      mem_w[ld_addr] <= ld_w;
      mem_v[ld_addr] <= ld_v;
      mem_g[ld_addr] <= ld_g;
    end
    if (we_w)    mem_w[waddr] <= wdata_w;
    if (we_v)    mem_v[waddr] <= wdata_v;
    if (we_grad) mem_g[waddr] <= wdata_grad;
  end

  // Reference model: plain integers per lane
  int mw [DEPTH][LANES];
  int mv [DEPTH][LANES];
  int mg [DEPTH][LANES];
  logic [DW-1:0] ew [DEPTH];
  logic [DW-1:0] ev [DEPTH];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int clamp(input int x);
    if (x > 32767)  return 32767;
    if (x < -32768) return -32768;
    return x;
  endfunction

  // floor(x / d) for positive d
  function automatic int fdiv(input int x, input int d);
    int q;
    q = x / d;
    if ((x % d != 0) && (x < 0)) q = q - 1;
    return q;
  endfunction

  function automatic int lane_of(input logic [DW-1:0] word, input int l);
    logic [WIDTH-1:0] s;
    s = word[l*WIDTH +: WIDTH];
    return int'($signed(s));
  endfunction

  function automatic logic [DW-1:0] pk(input int row [LANES]);
    logic [DW-1:0] r;
    logic [31:0]   t;
    r = '0;
    for (int l = 0; l < LANES; l++) begin
      t = row[l];
      r[l*WIDTH +: WIDTH] = t[WIDTH-1:0];
    end
    return r;
  endfunction

  task automatic model_step(input int a);
    int nv, nw;
    for (int l = 0; l < LANES; l++) begin
      nv = clamp(mv[a][l] - fdiv(mv[a][l], 8) + mg[a][l]);
      nw = clamp(mw[a][l] - fdiv(nv, 16));
      mv[a][l] = nv;
      mw[a][l] = nw;
    end
    ew[a] = pk(mw[a]);
    ev[a] = pk(mv[a]);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int a, input logic [DW-1:0] w, input logic [DW-1:0] v,
                      input logic [DW-1:0] g);
    ld_en = 1'b1; ld_addr = AW'(a); ld_w = w; ld_v = v; ld_g = g;
    for (int l = 0; l < LANES; l++) begin
      mw[a][l] = lane_of(w, l);
      mv[a][l] = lane_of(v, l);
      mg[a][l] = lane_of(g, l);
    end
    tick();
    ld_en = 1'b0;
  endtask

  task automatic load_all(input logic [DW-1:0] w, input logic [DW-1:0] v,
                          input logic [DW-1:0] g);
    for (int a = 0; a < DEPTH; a++) load(a, w, v, g);
  endtask

  task automatic load_random();
    for (int a = 0; a < DEPTH; a++) load(a, $urandom, $urandom, $urandom);
  endtask

  task automatic compare_ram();
    for (int a = 0; a < DEPTH; a++) begin
      check("ram_w", mem_w[a], pk(mw[a]));
      check("ram_v", mem_v[a], pk(mv[a]));
      check("ram_g", mem_g[a], pk(mg[a]));
    end
  endtask

  // Starts in the current cycle (cycle 0); returns in the valid_update cycle.
  task automatic do_update(input bit with_zero);
    for (int a = 0; a < DEPTH; a++) model_step(a);
    update = 1'b1; zero_grad = with_zero;
    tick();
    update = 1'b0; zero_grad = 1'b0;
    for (int k = 1; k <= DEPTH + 3; k++) begin
      check("upd_busy", busy, k < DEPTH + 3);
      check("upd_valid", valid_update, k == DEPTH + 3);
      check("upd_we", {we_w, we_v}, (k >= 3 && k <= DEPTH + 2) ? 2'b11 : 2'b00);
      check("upd_we_grad", we_grad, 0);
      if (k <= DEPTH) check("upd_raddr", raddr, k - 1);
      if (k >= 3 && k <= DEPTH + 2) begin
        check("upd_waddr", waddr, k - 3);
        check("upd_wdata_w", wdata_w, ew[k-3]);
        check("upd_wdata_v", wdata_v, ev[k-3]);
      end
      if (k < DEPTH + 3) tick();
    end
  endtask

  task automatic do_zero();
    for (int a = 0; a < DEPTH; a++)
      for (int l = 0; l < LANES; l++) mg[a][l] = 0;
    zero_grad = 1'b1;
    tick();
    zero_grad = 1'b0;
    for (int k = 1; k <= DEPTH + 1; k++) begin
      check("zg_busy", busy, k <= DEPTH);
      check("zg_valid", valid_zero_grad, k == DEPTH + 1);
      check("zg_we_grad", we_grad, k <= DEPTH);
      check("zg_we_wv", {we_w, we_v}, 2'b00);
      if (k <= DEPTH) begin
        check("zg_waddr", waddr, k - 1);
        check("zg_wdata", wdata_grad, 0);
      end
      if (k <= DEPTH) tick();
    end
  endtask

  task automatic check_all_zero(input string tag);
    check(tag, {busy, valid_update, valid_zero_grad, we_w, we_v, we_grad}, 6'b0);
    check(tag, {raddr, waddr}, '0);
    check(tag, {wdata_w, wdata_v}, '0);
    check(tag, wdata_grad, '0);
  endtask

  initial begin
    rst = 1'b1; update = 1'b1; zero_grad = 1'b1;
    ld_en = 1'b0; ld_addr = '0; ld_w = '0; ld_v = '0; ld_g = '0;
    // Requests held during reset must be ignored
    repeat (3) begin
      tick();
      check_all_zero("reset");
    end
    rst = 1'b0; update = 1'b0; zero_grad = 1'b0;
    tick();
    check("idle_busy", busy, 0);

    // Nominal
    load_all(32'h1000_1000, 32'h0100_0100, 32'h0080_0080);
    do_update(1'b0);
    check("nominal_v", mem_v[0], 32'h0160_0160);
    check("nominal_w", mem_w[3], 32'h0FEA_0FEA);
    compare_ram();

    // Saturation
    load_all(32'h8000_8000, 32'h7FF0_7FF0, 32'h7FFF_7FFF);
    do_update(1'b0);
    check("sat_v", mem_v[1], 32'h7FFF_7FFF);
    check("sat_w", mem_w[2], 32'h8000_8000);
    compare_ram();

    // Negative arithmetic shift
    load_all(32'h0000_0000, 32'hFF00_FF00, 32'h0000_0000);
    do_update(1'b0);
    check("neg_v", mem_v[0], 32'hFF20_FF20);
    check("neg_w", mem_w[0], 32'h000E_000E);
    compare_ram();

    // Zero pass
    load_random();
    do_zero();
    compare_ram();

    // Priority: both requests -> update only
    load_random();
    do_update(1'b1);
    tick();
    check("prio_idle", {busy, we_grad}, 2'b00);
    compare_ram();

    // Random passes, the last two back-to-back
    for (int i = 0; i < 4; i++) begin
      load_random();
      do_update(1'b0);
      compare_ram();
    end
    do_update(1'b0);
    do_update(1'b0);
    compare_ram();
    // Zero pass back-to-back after update
    do_zero();
    compare_ram();

    // Abort mid-pass: reset in cycle 3, only address 0 was written
    load_random();
    model_step(0);
    update = 1'b1;
    tick();
    update = 1'b0;
    tick();
    tick();
    check("abort_we", {we_w, waddr}, {1'b1, 9'd0});
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_all_zero("abort");
    for (int k = 0; k < 8; k++) begin
      check("abort_quiet", {busy, valid_update, valid_zero_grad, we_w, we_v, we_grad}, 6'b0);
      tick();
    end
    compare_ram();
    do_update(1'b0);
    compare_ram();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
